// File: rtl/baser_257b_check_ctrl_if.sv
// Control/result bus between the test-control registers, the 257b checker counters and the run controller.
interface baser_257b_check_ctrl_if #(
  parameter int unsigned CNT_WIDTH = 32
);
  logic                 i_start;
  logic                 i_abort;
  logic [CNT_WIDTH-1:0] i_window_len;
  logic [CNT_WIDTH-1:0] i_max_inv;
  logic [CNT_WIDTH-1:0] i_block_count;
  logic [CNT_WIDTH-1:0] i_data_count;
  logic [CNT_WIDTH-1:0] i_ctrl_count;
  logic [CNT_WIDTH-1:0] i_inv_block_count;
  logic                 o_chk_rst;
  logic                 o_busy;
  logic                 o_done;
  logic                 o_aborted;
  logic                 o_cfg_err;
  logic                 o_pass;
  logic                 o_sync_err;
  logic [CNT_WIDTH-1:0] o_res_blocks;
  logic [CNT_WIDTH-1:0] o_res_data;
  logic [CNT_WIDTH-1:0] o_res_ctrl;
  logic [CNT_WIDTH-1:0] o_res_inv;
  logic [2:0]           o_state;

  modport master (
    output i_start, i_abort, i_window_len, i_max_inv,
           i_block_count, i_data_count, i_ctrl_count, i_inv_block_count,
    input  o_chk_rst, o_busy, o_done, o_aborted, o_cfg_err, o_pass, o_sync_err,
           o_res_blocks, o_res_data, o_res_ctrl, o_res_inv, o_state
  );

  modport slave (
    input  i_start, i_abort, i_window_len, i_max_inv,
           i_block_count, i_data_count, i_ctrl_count, i_inv_block_count,
    output o_chk_rst, o_busy, o_done, o_aborted, o_cfg_err, o_pass, o_sync_err,
           o_res_blocks, o_res_data, o_res_ctrl, o_res_inv, o_state
  );
endinterface

// File: rtl/baser_257b_check_ctrl.sv
// Run controller for the 257b BASE-R checker: flush, warm up, measure a block window,
// then report counter deltas and a pass/fail verdict.
module baser_257b_check_ctrl #(
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned FLUSH_CYCLES  = 4,
  parameter int unsigned WARMUP_BLOCKS = 16
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  baser_257b_check_ctrl_if.slave bus
);
  localparam int unsigned CW = CNT_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    WARMUP  = 3'd2,
    MEASURE = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [CW-1:0] win, max_inv;
  logic [CW-1:0] base_blk, base_dat, base_ctl, base_inv;
  logic          meas_first;
  logic          accept_c, cfg_err_c, abort_c, report_c;
  logic [CW-1:0] d_blk_c, d_dat_c, d_ctl_c, d_inv_c;
  logic          sync_c, pass_c;

  logic          chk_rst, busy, done, aborted, cfg_err, pass, sync_err;
  logic [CW-1:0] res_blk, res_dat, res_ctl, res_inv;

  // Deltas are taken modulo 2^CW so a wrapping checker counter still measures correctly
  assign d_blk_c = bus.i_block_count     - base_blk;
  assign d_dat_c = bus.i_data_count      - base_dat;
  assign d_ctl_c = bus.i_ctrl_count      - base_ctl;
  assign d_inv_c = bus.i_inv_block_count - base_inv;
  assign sync_c  = (d_blk_c != win);
  assign pass_c  = (d_inv_c <= max_inv) && !sync_c;

  // Next-state and per-phase cycle counter
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept_c   = 1'b0;
    cfg_err_c  = 1'b0;
    abort_c    = 1'b0;
    report_c   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.i_start && !bus.i_abort) begin
          if (bus.i_window_len == '0) begin
            cfg_err_c = 1'b1;
          end else begin
            accept_c   = 1'b1;
            state_next = FLUSH;
            cnt_next   = CW'(FLUSH_CYCLES);
          end
        end
      end
      FLUSH: begin
        if (cnt <= CW'(1)) begin
          if (WARMUP_BLOCKS == 0) begin
            state_next = MEASURE;
            cnt_next   = win;
          end else begin
            state_next = WARMUP;
            cnt_next   = CW'(WARMUP_BLOCKS);
          end
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      WARMUP: begin
        if (cnt <= CW'(1)) begin
          state_next = MEASURE;
          cnt_next   = win;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      MEASURE: begin
        if (cnt <= CW'(1)) begin
          state_next = REPORT;
        end else begin
          cnt_next = cnt - CW'(1);
        end
      end
      REPORT: begin
        report_c   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides everything while busy, including a pending report capture
    if (state != IDLE && bus.i_abort) begin
      state_next = IDLE;
      abort_c    = 1'b1;
      report_c   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      win        <= '0;
      max_inv    <= '0;
      base_blk   <= '0;
      base_dat   <= '0;
      base_ctl   <= '0;
      base_inv   <= '0;
      meas_first <= 1'b0;
      chk_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cfg_err    <= 1'b0;
      pass       <= 1'b0;
      sync_err   <= 1'b0;
      res_blk    <= '0;
      res_dat    <= '0;
      res_ctl    <= '0;
      res_inv    <= '0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      meas_first <= (state_next == MEASURE) && (state != MEASURE);
      if (accept_c) begin
        win     <= bus.i_window_len;
        max_inv <= bus.i_max_inv;
      end
      if (meas_first) begin
        base_blk <= bus.i_block_count;
        base_dat <= bus.i_data_count;
        base_ctl <= bus.i_ctrl_count;
        base_inv <= bus.i_inv_block_count;
      end
      if (report_c) begin
        res_blk  <= d_blk_c;
        res_dat  <= d_dat_c;
        res_ctl  <= d_ctl_c;
        res_inv  <= d_inv_c;
        sync_err <= sync_c;
        pass     <= pass_c;
      end
      done    <= report_c;
      aborted <= abort_c;
      cfg_err <= cfg_err_c;
      chk_rst <= (state_next == IDLE) || (state_next == FLUSH);
      busy    <= (state_next != IDLE);
    end
  end

  assign bus.o_state      = state;
  assign bus.o_chk_rst    = chk_rst;
  assign bus.o_busy       = busy;
  assign bus.o_done       = done;
  assign bus.o_aborted    = aborted;
  assign bus.o_cfg_err    = cfg_err;
  assign bus.o_pass       = pass;
  assign bus.o_sync_err   = sync_err;
  assign bus.o_res_blocks = res_blk;
  assign bus.o_res_data   = res_dat;
  assign bus.o_res_ctrl   = res_ctl;
  assign bus.o_res_inv    = res_inv;
endmodule

// File: tb/tb_baser_257b_check_ctrl.sv
// Bench for baser_257b_check_ctrl: random checker counter streams and runs, compared against a
// phase/timeline model and count-history deltas.
module tb_baser_257b_check_ctrl;
  localparam int unsigned CW = 32;
  localparam int F = 4;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  baser_257b_check_ctrl_if #(.CNT_WIDTH(CW)) bus ();

  baser_257b_check_ctrl #(
    .CNT_WIDTH    (CW),
    .FLUSH_CYCLES (F),
    .WARMUP_BLOCKS(W)
  ) dut (
    .clk    (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] blk = '0, dat = '0, ctl = '0, inv = '0;
  logic [31:0] hb[$], hd[$], hc[$], hi[$];
  bit next_inv = 1'b0;
  int inv_pct = 0, ctrl_pct = 0, skip_pct = 0;

  logic [31:0] e_blk = '0, e_dat = '0, e_ctl = '0, e_inv = '0;
  logic        e_pass = 1'b0, e_sync = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive_counts();
    bus.i_block_count     = blk;
    bus.i_data_count      = dat;
    bus.i_ctrl_count      = ctl;
    bus.i_inv_block_count = inv;
  endtask

  // One clock: advance the checker counter model and record what is presented this cycle
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (next_inv || int'($urandom_range(99)) >= skip_pct) begin
      blk++;
      if (next_inv || int'($urandom_range(99)) < inv_pct) inv++;
      else if (int'($urandom_range(99)) < ctrl_pct) ctl++;
      else dat++;
    end
    next_inv = 1'b0;
    drive_counts();
    hb.push_back(blk); hd.push_back(dat); hc.push_back(ctl); hi.push_back(inv);
  endtask

  task automatic preset(input logic [31:0] v);
    blk = v; dat = v; ctl = v; inv = v;
    drive_counts();
    hb[cyc] = blk; hd[cyc] = dat; hc[cyc] = ctl; hi[cyc] = inv;
  endtask

  // Expected phase d cycles after the start was accepted-edge window began
  function automatic logic [2:0] exp_state(input int d, input int len, input int ab);
    if (ab != 0 && d > ab) return 3'd0;
    if (d <= F) return 3'd1;
    if (d <= F + W) return 3'd2;
    if (d <= F + W + len) return 3'd3;
    if (d == F + W + len + 1) return 3'd4;
    return 3'd0;
  endfunction

  task automatic check_results(input string tag);
    chk({tag, "_blocks"}, bus.o_res_blocks, e_blk);
    chk({tag, "_data"},   bus.o_res_data,   e_dat);
    chk({tag, "_ctrl"},   bus.o_res_ctrl,   e_ctl);
    chk({tag, "_inv"},    bus.o_res_inv,    e_inv);
    chk({tag, "_pass"},   32'(bus.o_pass),     32'(e_pass));
    chk({tag, "_sync"},   32'(bus.o_sync_err), 32'(e_sync));
  endtask

  task automatic run(input logic [31:0] win, input logic [31:0] mx, input int ab,
                     input bit inj3, input bit busy_starts);
    int s, len, end_d, b0, b1;
    logic [2:0] st;
    len = int'(win);
    s = cyc;
    bus.i_window_len = win;
    bus.i_max_inv    = mx;
    bus.i_start      = 1'b1;
    bus.i_abort      = 1'b0;
    end_d = (ab != 0) ? ab + 1 : F + W + len + 2;
    for (int d = 1; d <= end_d; d++) begin
      if (inj3 && (d == F + W + 10 || d == F + W + 30 || d == F + W + 60)) next_inv = 1'b1;
      tick();
      bus.i_start      = busy_starts && (d < end_d) && ($urandom_range(7) == 0);
      bus.i_window_len = ($urandom_range(3) == 0) ? 32'd0 : $urandom;
      bus.i_max_inv    = $urandom;
      bus.i_abort      = (d == ab);
      st = exp_state(d, len, ab);
      chk("state",   32'(bus.o_state),   32'(st));
      chk("chk_rst", 32'(bus.o_chk_rst), 32'(st <= 3'd1));
      chk("busy",    32'(bus.o_busy),    32'(st != 3'd0));
      chk("done",    32'(bus.o_done),    32'(ab == 0 && d == F + W + len + 2));
      chk("aborted", 32'(bus.o_aborted), 32'(ab != 0 && d == ab + 1));
      chk("cfg_err", 32'(bus.o_cfg_err), 32'd0);
    end
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    if (ab == 0) begin
      b0 = s + F + W + 1;
      b1 = s + F + W + len + 1;
      e_blk  = hb[b1] - hb[b0];
      e_dat  = hd[b1] - hd[b0];
      e_ctl  = hc[b1] - hc[b0];
      e_inv  = hi[b1] - hi[b0];
      e_sync = (e_blk != win);
      e_pass = (e_inv <= mx) && !e_sync;
    end
    check_results(ab == 0 ? "res" : "held");
  endtask

  initial begin
    int len, ab;
    logic [2:0] st;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_window_len = '0;
    bus.i_max_inv = '0;
    drive_counts();
    hb.push_back(blk); hd.push_back(dat); hc.push_back(ctl); hi.push_back(inv);

    // Reset state
    repeat (3) tick();
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_chk_rst", 32'(bus.o_chk_rst), 32'd1);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    check_results("rst");
    rst_n = 1'b1;
    tick();

    // Clean 1000-block window with stray starts while busy
    run(32'd1000, 32'd0, 0, 1'b0, 1'b1);
    chk("t1_blocks", bus.o_res_blocks, 32'd1000);
    chk("t1_data", bus.o_res_data, 32'd1000);
    chk("t1_inv", bus.o_res_inv, 32'd0);
    chk("t1_pass", 32'(bus.o_pass), 32'd1);

    // Three injected invalid blocks against two thresholds
    ctrl_pct = 10;
    run(32'd100, 32'd2, 0, 1'b1, 1'b0);
    chk("t2_inv", bus.o_res_inv, 32'd3);
    chk("t2_fail", 32'(bus.o_pass), 32'd0);
    run(32'd100, 32'd3, 0, 1'b1, 1'b0);
    chk("t2_inv_b", bus.o_res_inv, 32'd3);
    chk("t2_pass", 32'(bus.o_pass), 32'd1);

    // Baseline lands at 0xFFFF_FFF0 so the window wraps the counters
    preset(32'hFFFF_FFF0 - 32'(F + W + 1));
    run(32'd32, 32'd0, 0, 1'b0, 1'b0);
    chk("t3_blocks", bus.o_res_blocks, 32'd32);
    chk("t3_sync", 32'(bus.o_sync_err), 32'd0);

    // Abort on the 50th measure cycle
    run(32'd200, 32'd5, F + W + 50, 1'b0, 1'b1);

    // Zero window rejected
    bus.i_window_len = '0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    chk("cfg_pulse", 32'(bus.o_cfg_err), 32'd1);
    chk("cfg_state", 32'(bus.o_state), 32'd0);
    chk("cfg_busy", 32'(bus.o_busy), 32'd0);
    tick();
    chk("cfg_clear", 32'(bus.o_cfg_err), 32'd0);

    // Start together with abort in IDLE
    bus.i_window_len = 32'd10;
    bus.i_start = 1'b1;
    bus.i_abort = 1'b1;
    tick();
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    chk("sa_state", 32'(bus.o_state), 32'd0);
    chk("sa_aborted", 32'(bus.o_aborted), 32'd0);
    chk("sa_cfg_err", 32'(bus.o_cfg_err), 32'd0);
    tick();
    chk("sa_state2", 32'(bus.o_state), 32'd0);
    check_results("sa");

    // Reset dropped during warm-up
    bus.i_window_len = 32'd50;
    bus.i_max_inv = 32'd1;
    bus.i_start = 1'b1;
    for (int d = 1; d <= F + 3; d++) begin
      tick();
      bus.i_start = 1'b0;
      st = exp_state(d, 50, 0);
      chk("pre_rst_state", 32'(bus.o_state), 32'(st));
    end
    rst_n = 1'b0;
    tick();
    chk("mr_state", 32'(bus.o_state), 32'd0);
    chk("mr_chk_rst", 32'(bus.o_chk_rst), 32'd1);
    chk("mr_busy", 32'(bus.o_busy), 32'd0);
    chk("mr_done", 32'(bus.o_done), 32'd0);
    chk("mr_aborted", 32'(bus.o_aborted), 32'd0);
    e_blk = '0; e_dat = '0; e_ctl = '0; e_inv = '0; e_pass = 1'b0; e_sync = 1'b0;
    check_results("mr");
    rst_n = 1'b1;
    tick();
    run(32'd60, 32'd1, 0, 1'b0, 1'b1);

    // Random runs, some aborted anywhere in the run, some with dropped blocks
    for (int r = 0; r < 10; r++) begin
      inv_pct  = int'($urandom_range(5));
      skip_pct = int'($urandom_range(1));
      len = int'($urandom_range(250, 1));
      ab  = ($urandom_range(2) == 0) ? int'($urandom_range(F + W + len + 1, 1)) : 0;
      run(32'(len), 32'($urandom_range(4)), ab, 1'b0, 1'b1);
      if ($urandom_range(1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
